// File: rtl/spring_scheduler_if.sv
// Bus bundle between spring_scheduler and its spring table, vertex memory, evaluator and integrator.
// sat_out exists only when SPRING_SCHED_SAT_EN is defined.
interface spring_scheduler_if #(
    parameter int unsigned NUM_SPRINGS   = 16,
    parameter int unsigned NUM_VERTICES  = 8,
    parameter int unsigned POSITION_SIZE = 8,
    parameter int unsigned VELOCITY_SIZE = 8,
    parameter int unsigned FORCE_SIZE    = 8,
    parameter int unsigned ACC_SIZE      = 12
);
    localparam int unsigned SprW = (NUM_SPRINGS > 1) ? $clog2(NUM_SPRINGS) : 1;
    localparam int unsigned VtxW = $clog2(NUM_VERTICES);

    logic                     start_in;
    logic                     busy_out;
    logic                     done_out;
    logic [SprW-1:0]          spr_addr_out;
    logic [VtxW-1:0]          spr_v1_in;
    logic [VtxW-1:0]          spr_v2_in;
    logic [VtxW-1:0]          vtx_addr_out;
    logic [POSITION_SIZE-1:0] vtx_px_in, vtx_py_in;
    logic [VELOCITY_SIZE-1:0] vtx_vx_in, vtx_vy_in;
    logic [POSITION_SIZE-1:0] ev_p1x_out, ev_p1y_out, ev_p2x_out, ev_p2y_out;
    logic [VELOCITY_SIZE-1:0] ev_v1x_out, ev_v1y_out, ev_v2x_out, ev_v2y_out;
    logic [FORCE_SIZE-1:0]    ev_fx_in, ev_fy_in;
    logic [VtxW-1:0]          frc_addr_in;
    logic [ACC_SIZE-1:0]      frc_x_out, frc_y_out;
    logic                     frc_valid_out;
`ifdef SPRING_SCHED_SAT_EN
    logic                     sat_out;
`endif

    modport master (
`ifdef SPRING_SCHED_SAT_EN
        output sat_out,
`endif
        input  start_in, spr_v1_in, spr_v2_in,
        input  vtx_px_in, vtx_py_in, vtx_vx_in, vtx_vy_in,
        input  ev_fx_in, ev_fy_in, frc_addr_in,
        output busy_out, done_out, spr_addr_out, vtx_addr_out,
        output ev_p1x_out, ev_p1y_out, ev_p2x_out, ev_p2y_out,
        output ev_v1x_out, ev_v1y_out, ev_v2x_out, ev_v2y_out,
        output frc_x_out, frc_y_out, frc_valid_out
    );

    modport slave (
`ifdef SPRING_SCHED_SAT_EN
        input  sat_out,
`endif
        output start_in, spr_v1_in, spr_v2_in,
        output vtx_px_in, vtx_py_in, vtx_vx_in, vtx_vy_in,
        output ev_fx_in, ev_fy_in, frc_addr_in,
        input  busy_out, done_out, spr_addr_out, vtx_addr_out,
        input  ev_p1x_out, ev_p1y_out, ev_p2x_out, ev_p2y_out,
        input  ev_v1x_out, ev_v1y_out, ev_v2x_out, ev_v2y_out,
        input  frc_x_out, frc_y_out, frc_valid_out
    );
endinterface

// File: rtl/spring_scheduler.sv
// Time-multiplexes one spring-force evaluator over all springs of a frame into per-vertex accumulators.
// Define SPRING_SCHED_SAT_EN for saturating accumulation with a sticky sat_out flag.
module spring_scheduler #(
    parameter int unsigned NUM_SPRINGS   = 16,
    parameter int unsigned NUM_VERTICES  = 8,
    parameter int unsigned POSITION_SIZE = 8,
    parameter int unsigned VELOCITY_SIZE = 8,
    parameter int unsigned FORCE_SIZE    = 8,
    parameter int unsigned ACC_SIZE      = 12
) (
    input logic                clk_in,
    input logic                rst_in,
    spring_scheduler_if.master bus
);
    localparam int unsigned SprW = (NUM_SPRINGS > 1) ? $clog2(NUM_SPRINGS) : 1;
    localparam int unsigned VtxW = $clog2(NUM_VERTICES);
    localparam logic [SprW-1:0] LastSpr = SprW'(NUM_SPRINGS - 1);
    localparam logic [VtxW-1:0] LastVtx = VtxW'(NUM_VERTICES - 1);

    typedef enum logic [3:0] {
        StIdle, StClear, StSprRd, StV1Rd, StV2Rd, StEval, StAcc2, StAcc1, StDone
    } state_e;

    state_e                   state_q, state_d;
    logic [SprW-1:0]          spr_idx_q;
    logic [VtxW-1:0]          clr_idx_q, i1_q, i2_q, vtx_addr;
    logic [FORCE_SIZE-1:0]    fx_q, fy_q;
    logic [POSITION_SIZE-1:0] p1x_q, p1y_q, p2x_q, p2y_q;
    logic [VELOCITY_SIZE-1:0] v1x_q, v1y_q, v2x_q, v2y_q;
    logic [ACC_SIZE-1:0]      frc_x_q, frc_y_q;
    logic                     valid_q;
    logic [ACC_SIZE-1:0]      acc_x_q [NUM_VERTICES];
    logic [ACC_SIZE-1:0]      acc_y_q [NUM_VERTICES];

    logic                     start_accept, acc_en, acc_sub;
    logic [VtxW-1:0]          acc_sel;
    logic [FORCE_SIZE-1:0]    f_x, f_y;
    logic [ACC_SIZE-1:0]      acc_new_x, acc_new_y;

`ifdef SPRING_SCHED_SAT_EN
    logic clamp_x, clamp_y, sat_q;

    function automatic logic [ACC_SIZE-1:0] acc_update(input logic [ACC_SIZE-1:0] a,
                                                       input logic [FORCE_SIZE-1:0] f,
                                                       input logic sub, output logic clamp);
        logic [ACC_SIZE:0] ea, ef, sum;
        ea    = (ACC_SIZE+1)'(signed'(a));
        ef    = (ACC_SIZE+1)'(signed'(f));
        sum   = sub ? ea - ef : ea + ef;
        clamp = sum[ACC_SIZE] ^ sum[ACC_SIZE-1];
        if (!clamp) return sum[ACC_SIZE-1:0];
        return sum[ACC_SIZE] ? {1'b1, {(ACC_SIZE-1){1'b0}}} : {1'b0, {(ACC_SIZE-1){1'b1}}};
    endfunction

    always_comb begin
        acc_new_x = acc_update(acc_x_q[acc_sel], f_x, acc_sub, clamp_x);
        acc_new_y = acc_update(acc_y_q[acc_sel], f_y, acc_sub, clamp_y);
    end

    assign bus.sat_out = sat_q;
`else
    function automatic logic [ACC_SIZE-1:0] acc_update(input logic [ACC_SIZE-1:0] a,
                                                       input logic [FORCE_SIZE-1:0] f,
                                                       input logic sub);
        logic [ACC_SIZE-1:0] ef;
        ef = ACC_SIZE'(signed'(f));
        return sub ? a - ef : a + ef;
    endfunction

    assign acc_new_x = acc_update(acc_x_q[acc_sel], f_x, acc_sub);
    assign acc_new_y = acc_update(acc_y_q[acc_sel], f_y, acc_sub);
`endif

    assign start_accept = (state_q == StIdle) && bus.start_in;
    assign acc_en       = (state_q == StAcc2) || (state_q == StAcc1);
    assign acc_sub      = (state_q == StAcc1);
    assign acc_sel      = acc_sub ? i1_q : i2_q;
    // ACC1 reuses the force held from ACC2 so both endpoints see one value.
    assign f_x          = acc_sub ? fx_q : bus.ev_fx_in;
    assign f_y          = acc_sub ? fy_q : bus.ev_fy_in;

    always_comb begin
        state_d  = state_q;
        vtx_addr = '0;
        case (state_q)
            StIdle:  if (bus.start_in) state_d = StClear;
            StClear: if (clr_idx_q == LastVtx) state_d = StSprRd;
            StSprRd: state_d = StV1Rd;
            StV1Rd: begin
                state_d  = StV2Rd;
                vtx_addr = bus.spr_v1_in;
            end
            StV2Rd: begin
                state_d  = StEval;
                vtx_addr = i2_q;
            end
            StEval:  state_d = StAcc2;
            StAcc2:  state_d = StAcc1;
            StAcc1:  state_d = (spr_idx_q == LastSpr) ? StDone : StSprRd;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= StIdle;
            spr_idx_q <= '0;
            clr_idx_q <= '0;
            i1_q      <= '0;
            i2_q      <= '0;
            fx_q      <= '0;
            fy_q      <= '0;
            {p1x_q, p1y_q, p2x_q, p2y_q} <= '0;
            {v1x_q, v1y_q, v2x_q, v2y_q} <= '0;
            frc_x_q   <= '0;
            frc_y_q   <= '0;
            valid_q   <= 1'b0;
`ifdef SPRING_SCHED_SAT_EN
            sat_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            frc_x_q <= acc_x_q[bus.frc_addr_in];
            frc_y_q <= acc_y_q[bus.frc_addr_in];
            if (state_q == StIdle) begin
                spr_idx_q <= '0;
                clr_idx_q <= '0;
            end
            if (state_q == StClear) clr_idx_q <= clr_idx_q + 1'b1;
            if (state_q == StV1Rd) begin
                i1_q <= bus.spr_v1_in;
                i2_q <= bus.spr_v2_in;
            end
            if (state_q == StV2Rd) begin
                p1x_q <= bus.vtx_px_in;
                p1y_q <= bus.vtx_py_in;
                v1x_q <= bus.vtx_vx_in;
                v1y_q <= bus.vtx_vy_in;
            end
            if (state_q == StEval) begin
                p2x_q <= bus.vtx_px_in;
                p2y_q <= bus.vtx_py_in;
                v2x_q <= bus.vtx_vx_in;
                v2y_q <= bus.vtx_vy_in;
            end
            if (state_q == StAcc2) begin
                fx_q <= bus.ev_fx_in;
                fy_q <= bus.ev_fy_in;
            end
            if (state_q == StAcc1 && spr_idx_q != LastSpr) spr_idx_q <= spr_idx_q + 1'b1;
            if (start_accept) valid_q <= 1'b0;
            else if (state_d == StDone) valid_q <= 1'b1;
`ifdef SPRING_SCHED_SAT_EN
            if (start_accept) sat_q <= 1'b0;
            else if (acc_en && (clamp_x || clamp_y)) sat_q <= 1'b1;
`endif
        end
    end

    // Accumulator storage is deliberately left out of reset; CLEAR zeroes it each frame.
    always_ff @(posedge clk_in) begin
        if (state_q == StClear) begin
            acc_x_q[clr_idx_q] <= '0;
            acc_y_q[clr_idx_q] <= '0;
        end else if (acc_en) begin
            acc_x_q[acc_sel] <= acc_new_x;
            acc_y_q[acc_sel] <= acc_new_y;
        end
    end

    assign bus.busy_out      = (state_q != StIdle) && (state_q != StDone);
    assign bus.done_out      = (state_q == StDone);
    assign bus.spr_addr_out  = spr_idx_q;
    assign bus.vtx_addr_out  = vtx_addr;
    assign bus.ev_p1x_out    = p1x_q;
    assign bus.ev_p1y_out    = p1y_q;
    assign bus.ev_p2x_out    = p2x_q;
    assign bus.ev_p2y_out    = p2y_q;
    assign bus.ev_v1x_out    = v1x_q;
    assign bus.ev_v1y_out    = v1y_q;
    assign bus.ev_v2x_out    = v2x_q;
    assign bus.ev_v2y_out    = v2y_q;
    assign bus.frc_x_out     = frc_x_q;
    assign bus.frc_y_out     = frc_y_q;
    assign bus.frc_valid_out = valid_q;
endmodule

// File: tb/tb_spring_scheduler.sv
// Scoreboard bench for spring_scheduler: 2 springs, 4 vertices, 8-bit accumulators.
// Evaluator stub: f = (p2 - p1) + (v2 - v1) + bias, per axis.
module tb_spring_scheduler;
    localparam int unsigned NS = 2;
    localparam int unsigned NV = 4;
    localparam int unsigned FrameLen = NV + 6 * NS;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spring_scheduler_if #(
        .NUM_SPRINGS(NS), .NUM_VERTICES(NV), .POSITION_SIZE(8),
        .VELOCITY_SIZE(8), .FORCE_SIZE(8), .ACC_SIZE(8)
    ) bus ();

    spring_scheduler #(
        .NUM_SPRINGS(NS), .NUM_VERTICES(NV), .POSITION_SIZE(8),
        .VELOCITY_SIZE(8), .FORCE_SIZE(8), .ACC_SIZE(8)
    ) dut (
        .clk_in(clk),
        .rst_in(rst_n),
        .bus   (bus)
    );

    logic [1:0] tbl_v1 [NS];
    logic [1:0] tbl_v2 [NS];
    logic [7:0] m_px [NV], m_py [NV], m_vx [NV], m_vy [NV];
    logic [7:0] bias_x, bias_y;
    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0] addr;
        logic [7:0] x;
        logic [7:0] y;
    } exp_t;
    exp_t exp_q[$];
    logic rd_req = 1'b0;
    logic rd_vld = 1'b0;

    // Spring table and vertex memory, one-cycle read latency.
    always @(posedge clk) begin
        bus.spr_v1_in <= tbl_v1[bus.spr_addr_out];
        bus.spr_v2_in <= tbl_v2[bus.spr_addr_out];
        bus.vtx_px_in <= m_px[bus.vtx_addr_out];
        bus.vtx_py_in <= m_py[bus.vtx_addr_out];
        bus.vtx_vx_in <= m_vx[bus.vtx_addr_out];
        bus.vtx_vy_in <= m_vy[bus.vtx_addr_out];
        rd_vld        <= rd_req;
    end

    always_comb begin
        bus.ev_fx_in = bus.ev_p2x_out - bus.ev_p1x_out + bus.ev_v2x_out - bus.ev_v1x_out + bias_x;
        bus.ev_fy_in = bus.ev_p2y_out - bus.ev_p1y_out + bus.ev_v2y_out - bus.ev_v1y_out + bias_y;
    end

    // Monitor: compares each completed force read against the queued expectation.
    always @(negedge clk) begin
        if (rd_vld) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL frc_read: got a read with no expectation queued");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (bus.frc_x_out !== e.x || bus.frc_y_out !== e.y) begin
                    errors++;
                    $display("FAIL frc[%0d]: got (%0d,%0d) expected (%0d,%0d)", e.addr,
                             $signed(bus.frc_x_out), $signed(bus.frc_y_out),
                             $signed(e.x), $signed(e.y));
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    function automatic logic outs_nonzero();
        return |{bus.busy_out, bus.done_out, bus.spr_addr_out, bus.vtx_addr_out,
                 bus.ev_p1x_out, bus.ev_p1y_out, bus.ev_p2x_out, bus.ev_p2y_out,
                 bus.ev_v1x_out, bus.ev_v1y_out, bus.ev_v2x_out, bus.ev_v2y_out,
                 bus.frc_x_out, bus.frc_y_out, bus.frc_valid_out
`ifdef SPRING_SCHED_SAT_EN
                 , bus.sat_out
`endif
                 };
    endfunction

    task automatic clear_vtx();
        for (int i = 0; i < NV; i++) begin
            m_px[i] = '0; m_py[i] = '0; m_vx[i] = '0; m_vy[i] = '0;
        end
    endtask

    task automatic set_vtx(input int v, input logic [7:0] px, input logic [7:0] py,
                           input logic [7:0] vx, input logic [7:0] vy);
        m_px[v] = px; m_py[v] = py; m_vx[v] = vx; m_vy[v] = vy;
    endtask

    task automatic set_spr(input int s, input logic [1:0] a, input logic [1:0] b);
        tbl_v1[s] = a;
        tbl_v2[s] = b;
    endtask

    task automatic read_frc(input logic [1:0] a, input logic [7:0] ex, input logic [7:0] ey);
        @(negedge clk);
        bus.frc_addr_in = a;
        rd_req = 1'b1;
        exp_q.push_back('{a, ex, ey});
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    // k counts negedge samples after the accepting edge; done is due at k == FrameLen.
    task automatic run_frame(input bit poke);
        int done_cnt;
        int done_k;
        done_cnt = 0;
        done_k   = -1;
        @(negedge clk);
        bus.start_in = 1'b1;
        @(negedge clk);
        bus.start_in = 1'b0;
        for (int k = 0; k < int'(FrameLen) + 3; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 0) begin
                check("busy_after_start", int'(bus.busy_out), 1);
                check("valid_cleared_on_start", int'(bus.frc_valid_out), 0);
            end
            if (poke) begin
                if (k == 3) bus.start_in = 1'b1;
                if (k == 4) bus.start_in = 1'b0;
                if (k == int'(FrameLen)) bus.start_in = 1'b1;
                if (k == int'(FrameLen) + 1) bus.start_in = 1'b0;
            end
            for (int s = 0; s < NS; s++) begin
                if (k == int'(NV) + 6 * s) check("spr_addr", int'(bus.spr_addr_out), s);
                if (k == int'(NV) + 6 * s + 1)
                    check("vtx_addr_i1", int'(bus.vtx_addr_out), int'(tbl_v1[s]));
                if (k == int'(NV) + 6 * s + 2)
                    check("vtx_addr_i2", int'(bus.vtx_addr_out), int'(tbl_v2[s]));
            end
            if (bus.done_out === 1'b1) begin
                done_cnt++;
                if (done_k < 0) begin
                    done_k = k;
                    check("valid_at_done", int'(bus.frc_valid_out), 1);
                    check("busy_low_at_done", int'(bus.busy_out), 0);
                end
            end
            if (k == int'(FrameLen) + 1) check("idle_after_done", int'(bus.busy_out), 0);
        end
        check("done_latency", done_k, int'(FrameLen));
        check("done_count", done_cnt, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcnt;
        rst_n = 1'b0;
        bus.start_in = 1'b0;
        bus.frc_addr_in = '0;
        bias_x = '0;
        bias_y = '0;
        clear_vtx();
        set_spr(0, 2'd0, 2'd1);
        set_spr(1, 2'd0, 2'd1);
        repeat (2) @(negedge clk);
        check("reset_outputs_zero", int'(outs_nonzero()), 0);
        rst_n = 1'b1;

        // Frame 1: springs (0,1),(2,3); expected (3,-2) and (-2,2) forces.
        set_spr(0, 2'd0, 2'd1);
        set_spr(1, 2'd2, 2'd3);
        set_vtx(1, 8'd3, 8'hfe, 8'd0, 8'd0);
        set_vtx(2, 8'd10, 8'd20, 8'd1, 8'd2);
        set_vtx(3, 8'd4, 8'd25, 8'd5, 8'hff);
        run_frame(1'b0);
        read_frc(2'd0, 8'hfd, 8'd2);
        read_frc(2'd1, 8'd3, 8'hfe);
        read_frc(2'd2, 8'd2, 8'hfe);
        read_frc(2'd3, 8'hfe, 8'd2);

        // Frame 2: two copies of (0,1) with force (5,5); vertices 2/3 must come back cleared.
        clear_vtx();
        set_spr(0, 2'd0, 2'd1);
        set_spr(1, 2'd0, 2'd1);
        set_vtx(1, 8'd5, 8'd5, 8'd0, 8'd0);
        run_frame(1'b0);
        read_frc(2'd1, 8'd10, 8'd10);
        read_frc(2'd0, 8'hf6, 8'hf6);
        read_frc(2'd2, 8'd0, 8'd0);
        read_frc(2'd3, 8'd0, 8'd0);
`ifdef SPRING_SCHED_SAT_EN
        check("sat_clear", int'(bus.sat_out), 0);
`endif

        // Frame 3: degenerate springs (2,2) with bias force (7,7); stray starts while busy.
        clear_vtx();
        set_spr(0, 2'd2, 2'd2);
        set_spr(1, 2'd2, 2'd2);
        bias_x = 8'd7;
        bias_y = 8'd7;
        run_frame(1'b1);
        bias_x = '0;
        bias_y = '0;
        read_frc(2'd2, 8'd0, 8'd0);
        read_frc(2'd0, 8'd0, 8'd0);

        // Frame 4: force (127,0) twice into 8-bit accumulators.
        clear_vtx();
        set_spr(0, 2'd0, 2'd1);
        set_spr(1, 2'd0, 2'd1);
        set_vtx(1, 8'd127, 8'd0, 8'd0, 8'd0);
        run_frame(1'b0);
`ifdef SPRING_SCHED_SAT_EN
        read_frc(2'd1, 8'h7f, 8'd0);
        read_frc(2'd0, 8'h80, 8'd0);
        check("sat_set", int'(bus.sat_out), 1);
`else
        read_frc(2'd1, 8'hfe, 8'd0);
        read_frc(2'd0, 8'd2, 8'd0);
`endif

        // Reset during EVAL of spring 0 = (1,0): ev_p1 holds vertex 1 data beforehand.
        clear_vtx();
        set_spr(0, 2'd1, 2'd0);
        set_spr(1, 2'd1, 2'd0);
        set_vtx(1, 8'd5, 8'd5, 8'd0, 8'd0);
        @(negedge clk);
        bus.start_in = 1'b1;
        @(negedge clk);
        bus.start_in = 1'b0;
        repeat (NV + 3) @(negedge clk);
        check("ev_p1x_before_reset", int'(bus.ev_p1x_out), 5);
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_midframe_outputs_zero", int'(outs_nonzero()), 0);
        check("reset_midframe_valid", int'(bus.frc_valid_out), 0);
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < int'(FrameLen) + 4; i++) begin
            @(negedge clk);
            if (bus.done_out === 1'b1) dcnt++;
        end
        check("no_done_after_abort", dcnt, 0);
        check("idle_after_abort", int'(bus.busy_out), 0);

        // Fresh full frame after the abort.
        set_spr(0, 2'd0, 2'd1);
        set_spr(1, 2'd0, 2'd1);
        run_frame(1'b0);
        read_frc(2'd1, 8'd10, 8'd10);
        read_frc(2'd0, 8'hf6, 8'hf6);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
